// File: rtl/psum_accum_pkg.sv
// Shared types and constants for the partial-sum accumulator.
package psum_accum_pkg;

    localparam int LANE_W    = 16;
    localparam int PROD_W    = 32;
    localparam int NUM_LANES = PROD_W / LANE_W;
    localparam int ACC_W_DEF = 24;
    localparam int LEN_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/psum_accum_if.sv
// Product-beat input and psum output handshakes of psum_accum.
interface psum_accum_if
    import psum_accum_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] prod;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_psum;
    logic              out_ovf;

    modport master (
        output in_valid, prod, out_ready,
        input  in_ready, out_valid, out_psum, out_ovf
    );

    modport slave (
        input  in_valid, prod, out_ready,
        output in_ready, out_valid, out_psum, out_ovf
    );
endinterface

// File: rtl/psum_accum_lane_adder.sv
// Lane reduction plus overflow-checked accumulator update.
// PSUM_SAT_EN selects saturating instead of wrapping accumulation.
module lane_adder
    import psum_accum_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [PROD_W-1:0] prod,
    input  logic [ACC_W-1:0]  acc,
    input  logic              first,
    output logic [ACC_W-1:0]  acc_nxt,
    output logic              ovf
);
    logic [NUM_LANES-1:0][LANE_W-1:0] lanes;
    logic [LANE_W:0]                  beat_sum;
    logic [ACC_W:0]                   sum_w;

    assign lanes = prod;

    // first beat of a psum starts from zero rather than the stale acc
    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < NUM_LANES; i++)
            beat_sum = beat_sum + {1'b0, lanes[i]};
        sum_w = (first ? '0 : {1'b0, acc}) + {{(ACC_W - LANE_W){1'b0}}, beat_sum};
    end

    assign ovf = sum_w[ACC_W];

`ifdef PSUM_SAT_EN
    assign acc_nxt = ovf ? '1 : sum_w[ACC_W-1:0];
`else
    assign acc_nxt = sum_w[ACC_W-1:0];
`endif

endmodule

// File: rtl/psum_accum.sv
// Accumulates cfg_len two-lane product beats into one psum and holds it
// until downstream takes it. Optional macro: PSUM_SAT_EN (saturating acc).
module psum_accum
    import psum_accum_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [LEN_W-1:0] cfg_len,
    psum_accum_if.slave      bus
);
    state_t           state, state_nx;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [LEN_W-1:0] cnt, len, len_cfg, cnt_inc;
    logic             ovf, add_ovf;
    logic             rdy_en;
    logic             beat, handoff, in_idle;

    assign in_idle = (state == IDLE);
    assign len_cfg = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
    assign cnt_inc = cnt + 1'b1;
    assign beat    = bus.in_valid && bus.in_ready;
    assign handoff = (state == HOLD) && bus.out_ready;

    lane_adder #(.ACC_W(ACC_W)) u_add (
        .prod    (bus.prod),
        .acc     (acc),
        .first   (in_idle),
        .acc_nxt (acc_nxt),
        .ovf     (add_ovf)
    );

    // keeps in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_en <= 1'b0;
        else        rdy_en <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (beat) state_nx = (len_cfg == LEN_W'(1)) ? HOLD : ACCUM;
                ACCUM:   if (beat && cnt_inc == len) state_nx = HOLD;
                HOLD:    if (bus.out_ready) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = rdy_en && (state != HOLD) && !clear;
        bus.out_valid = (state == HOLD);
        bus.out_psum  = (state == HOLD) ? acc : '0;
        bus.out_ovf   = (state == HOLD) && ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            len <= LEN_W'(1);
            ovf <= 1'b0;
        end else if (clear || handoff) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (beat) begin
            acc <= acc_nxt;
            if (in_idle) begin
                cnt <= LEN_W'(1);
                len <= len_cfg;
                ovf <= add_ovf;
            end else begin
                cnt <= cnt_inc;
                ovf <= ovf | add_ovf;
            end
        end
    end

endmodule

// File: tb/tb_psum_accum.sv
// Directed bench for psum_accum: vector table plus multi-cycle corner sequences.
module tb_psum_accum;
    import psum_accum_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic [7:0] cfg_len;

    int checks = 0;
    int errors = 0;

    psum_accum_if #(.ACC_W(24)) bus ();
    psum_accum_if #(.ACC_W(17)) b17 ();

    psum_accum #(.ACC_W(24), .LEN_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .cfg_len(cfg_len), .bus(bus)
    );

    psum_accum #(.ACC_W(17), .LEN_W(8)) u_dut17 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .cfg_len(cfg_len), .bus(b17)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]       len;
        logic [2:0]       n;
        logic [3:0][31:0] b;
        logic [23:0]      psum;
        logic             ovf;
    } vec_t;

    vec_t tv [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic handoff();
        bus.out_ready = 1'b1;
        edge_();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] exp17;
        rst_n = 1'b0; clear = 1'b0; cfg_len = 8'd1;
        bus.in_valid = 1'b0; bus.prod = '0; bus.out_ready = 1'b0;
        b17.in_valid = 1'b0; b17.prod = '0; b17.out_ready = 1'b0;

        tv[0] = '{8'd3, 3'd3, {32'h0, 32'h0100_0000, 32'h0001_0002, 32'h0010_0020}, 24'h000133, 1'b0};
        tv[1] = '{8'd0, 3'd1, {32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF}, 24'h01FFFE, 1'b0};
        tv[2] = '{8'd1, 3'd1, {32'h0, 32'h0, 32'h0, 32'h1234_0001}, 24'h001235, 1'b0};
        tv[3] = '{8'd4, 3'd4, {32'h0001_0001, 32'h8000_8000, 32'h0000_FFFF, 32'hFFFF_0000}, 24'h030000, 1'b0};
        tv[4] = '{8'd2, 3'd2, {32'h0, 32'h0, 32'h0000_0000, 32'h0005_0005}, 24'h00000A, 1'b0};

        // reset state
        mid();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_psum", 32'(bus.out_psum), 32'd0);
        chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
        edge_();
        rst_n = 1'b1;
        mid();
        chk("rdy_before_edge", 32'(bus.in_ready), 32'd0);
        edge_();
        mid();
        chk("rdy_after_edge", 32'(bus.in_ready), 32'd1);
        edge_();

        // table-driven psums with immediate handoff
        for (int v = 0; v < 5; v++) begin
            cfg_len = tv[v].len;
            for (int i = 0; i < int'(tv[v].n); i++) begin
                bus.in_valid = 1'b1;
                bus.prod = tv[v].b[i];
                edge_();
            end
            bus.in_valid = 1'b0;
            mid();
            chk($sformatf("vec%0d_valid", v), 32'(bus.out_valid), 32'd1);
            chk($sformatf("vec%0d_psum", v), 32'(bus.out_psum), 32'(tv[v].psum));
            chk($sformatf("vec%0d_ovf", v), 32'(bus.out_ovf), 32'(tv[v].ovf));
            handoff();
            mid();
            chk($sformatf("vec%0d_idle", v), 32'(bus.out_valid), 32'd0);
        end

        // bubbles mid-psum and cfg_len change after first beat
        cfg_len = 8'd2;
        bus.in_valid = 1'b1; bus.prod = 32'h0000_0011;
        edge_();
        bus.in_valid = 1'b0; cfg_len = 8'd5;
        edge_(); edge_();
        mid();
        chk("bubble_no_out", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b1; bus.prod = 32'h0022_0000;
        edge_();
        bus.in_valid = 1'b0;
        mid();
        chk("bubble_valid", 32'(bus.out_valid), 32'd1);
        chk("bubble_psum", 32'(bus.out_psum), 32'h33);
        handoff();

        // backpressure
        cfg_len = 8'd2;
        bus.in_valid = 1'b1; bus.prod = 32'h0000_0001;
        edge_();
        bus.prod = 32'h0000_0002;
        edge_();
        bus.prod = 32'h0000_0007; cfg_len = 8'd1;
        for (int c = 0; c < 5; c++) begin
            mid();
            chk($sformatf("bp%0d_valid", c), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp%0d_psum", c), 32'(bus.out_psum), 32'd3);
            chk($sformatf("bp%0d_in_ready", c), 32'(bus.in_ready), 32'd0);
            edge_();
        end
        bus.out_ready = 1'b1;
        mid();
        chk("bp_handoff_rdy", 32'(bus.in_ready), 32'd0);
        edge_();
        bus.out_ready = 1'b0;
        mid();
        chk("bp_bubble_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_bubble_rdy", 32'(bus.in_ready), 32'd1);
        edge_();
        bus.in_valid = 1'b0;
        mid();
        chk("bp_next_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_next_psum", 32'(bus.out_psum), 32'd7);
        handoff();

        // clear during beat 2 of 4, then a 2-beat psum
        cfg_len = 8'd4;
        bus.in_valid = 1'b1; bus.prod = 32'h0000_0010;
        edge_();
        clear = 1'b1; bus.prod = 32'h0000_0100;
        mid();
        chk("clr_in_ready", 32'(bus.in_ready), 32'd0);
        edge_();
        clear = 1'b0; bus.in_valid = 1'b0;
        mid();
        chk("clr_no_out", 32'(bus.out_valid), 32'd0);
        cfg_len = 8'd2;
        bus.in_valid = 1'b1; bus.prod = 32'h0000_0003;
        edge_();
        bus.prod = 32'h0000_0004;
        edge_();
        bus.in_valid = 1'b0;
        mid();
        chk("clr_next_valid", 32'(bus.out_valid), 32'd1);
        chk("clr_next_psum", 32'(bus.out_psum), 32'd7);
        clear = 1'b1;
        edge_();
        clear = 1'b0;
        mid();
        chk("clr_hold_valid", 32'(bus.out_valid), 32'd0);
        chk("clr_hold_psum", 32'(bus.out_psum), 32'd0);

        // reset mid-psum
        cfg_len = 8'd3;
        bus.in_valid = 1'b1; bus.prod = 32'h0000_0005;
        edge_(); edge_();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("mrst_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_psum", 32'(bus.out_psum), 32'd0);
        edge_();
        rst_n = 1'b1;
        edge_();
        cfg_len = 8'd1;
        bus.in_valid = 1'b1; bus.prod = 32'h0002_0003;
        edge_();
        bus.in_valid = 1'b0;
        mid();
        chk("mrst_fresh_valid", 32'(bus.out_valid), 32'd1);
        chk("mrst_fresh_psum", 32'(bus.out_psum), 32'd5);
        handoff();

        // overflow on the 17-bit instance
`ifdef PSUM_SAT_EN
        exp17 = 32'h1FFFF;
`else
        exp17 = 32'h1FFFA;
`endif
        cfg_len = 8'd3;
        b17.in_valid = 1'b1; b17.prod = 32'hFFFF_FFFF;
        edge_(); edge_(); edge_();
        b17.in_valid = 1'b0;
        mid();
        chk("ovf_valid", 32'(b17.out_valid), 32'd1);
        chk("ovf_flag", 32'(b17.out_ovf), 32'd1);
        chk("ovf_psum", 32'(b17.out_psum), exp17);
        b17.out_ready = 1'b1;
        edge_();
        b17.out_ready = 1'b0;
        mid();
        chk("ovf_after_handoff", 32'(b17.out_ovf), 32'd0);
        cfg_len = 8'd1;
        b17.in_valid = 1'b1; b17.prod = 32'h0000_0001;
        edge_();
        b17.in_valid = 1'b0;
        mid();
        chk("ovf_clean_psum", 32'(b17.out_psum), 32'd1);
        chk("ovf_clean_flag", 32'(b17.out_ovf), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
